// File: rtl/keypad_event_fifo.sv
// Key-event queue behind the keypad scanner: edge-detects the scanner strobe,
// stores each key code in a small FWFT FIFO, and raises a level interrupt.
module keypad_event_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned THRESH = 1
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iKEY_IRQ,
  input  logic [7:0]    iKEYNUM,
  input  logic          iRD_EN,
  input  logic          iFLUSH,
  input  logic          iOVF_CLR,
  output logic [7:0]    oRD_DATA,
  output logic          oEMPTY,
  output logic          oFULL,
  output logic [AW:0]   oCOUNT,
  output logic          oOVF,
  output logic          oIRQ
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          prevIrq;

  logic          evt;
  logic          popOk;
  logic          pushOk;
  logic          drop;
  logic          wrEn;
  logic [CW-1:0] countNext;
  logic          ovfNext;

  // Event detect and push/pop arbitration; a pop on a full FIFO makes room for a same-edge push
  always_comb begin
    evt       = iKEY_IRQ & ~prevIrq;
    popOk     = iRD_EN & ~oEMPTY;
    pushOk    = evt & (~oFULL | popOk);
    drop      = evt & oFULL & ~popOk & ~iFLUSH;
    wrEn      = pushOk & ~iFLUSH & ~iRST;
    countNext = oCOUNT;
    ovfNext   = oOVF;
    if (iFLUSH) begin
      countNext = '0;
    end else if (pushOk && !popOk) begin
      countNext = oCOUNT + CW'(1);
    end else if (!pushOk && popOk) begin
      countNext = oCOUNT - CW'(1);
    end
    if (drop) begin
      ovfNext = 1'b1;
    end else if (iOVF_CLR) begin
      ovfNext = 1'b0;
    end
  end

  // Pointers, occupancy and registered flags; prevIrq resets high so a held strobe is not an event
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      prevIrq <= 1'b1;
      oCOUNT  <= '0;
      oEMPTY  <= 1'b1;
      oFULL   <= 1'b0;
      oOVF    <= 1'b0;
      oIRQ    <= 1'b0;
    end else begin
      prevIrq <= iKEY_IRQ;
      if (iFLUSH) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (pushOk) wrPtr <= wrPtr + AW'(1);
        if (popOk)  rdPtr <= rdPtr + AW'(1);
      end
      oCOUNT <= countNext;
      oEMPTY <= (countNext == '0);
      oFULL  <= (32'(countNext) == DEPTH);
      oOVF   <= ovfNext;
      oIRQ   <= (32'(countNext) >= THRESH);
    end
  end

  // Storage carries no reset
  always_ff @(posedge iCLK) begin
    if (wrEn) mem[wrPtr] <= iKEYNUM;
  end

  assign oRD_DATA = oEMPTY ? '0 : mem[rdPtr];

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Scoreboard bench for keypad_event_fifo: a queue model tracks accepted key
// codes and flags; popped data and all outputs are compared every cycle.
module tb_keypad_event_fifo;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iKEY_IRQ = 1'b0;
  logic [7:0] iKEYNUM = 8'h00;
  logic       iRD_EN = 1'b0;
  logic       iFLUSH = 1'b0;
  logic       iOVF_CLR = 1'b0;
  logic [7:0] oRD_DATA;
  logic       oEMPTY;
  logic       oFULL;
  logic [3:0] oCOUNT;
  logic       oOVF;
  logic       oIRQ;

  keypad_event_fifo #(.DEPTH(8), .AW(3), .THRESH(1)) dut (
    .iCLK(iCLK), .iRST(iRST), .iKEY_IRQ(iKEY_IRQ), .iKEYNUM(iKEYNUM),
    .iRD_EN(iRD_EN), .iFLUSH(iFLUSH), .iOVF_CLR(iOVF_CLR),
    .oRD_DATA(oRD_DATA), .oEMPTY(oEMPTY), .oFULL(oFULL), .oCOUNT(oCOUNT),
    .oOVF(oOVF), .oIRQ(oIRQ)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic mPrev = 1'b1;
  logic mOvf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output
  task automatic step(input logic rst, input logic key, input logic [7:0] num,
                      input logic rd, input logic fl, input logic oc);
    logic [7:0] preData;
    logic [7:0] popped;
    logic evt, popOk, drop;
    @(negedge iCLK);
    iRST = rst; iKEY_IRQ = key; iKEYNUM = num; iRD_EN = rd; iFLUSH = fl; iOVF_CLR = oc;
    #1 preData = oRD_DATA;
    @(posedge iCLK);
    #1;
    if (rst) begin
      q.delete();
      mPrev = 1'b1;
      mOvf = 1'b0;
    end else begin
      evt = key & ~mPrev;
      mPrev = key;
      drop = 1'b0;
      if (fl) begin
        q.delete();
      end else begin
        popOk = rd && (q.size() > 0);
        if (popOk) begin
          popped = q.pop_front();
          check("pop_data", 32'(preData), 32'(popped));
        end
        if (evt) begin
          if (q.size() < 8) q.push_back(num);
          else drop = 1'b1;
        end
      end
      if (drop) mOvf = 1'b1;
      else if (oc) mOvf = 1'b0;
    end
    check("count", 32'(oCOUNT), 32'(q.size()));
    check("empty", 32'(oEMPTY), 32'(q.size() == 0));
    check("full", 32'(oFULL), 32'(q.size() == 8));
    check("ovf", 32'(oOVF), 32'(mOvf));
    check("irq", 32'(oIRQ), 32'(q.size() >= 1));
    check("rd_data", 32'(oRD_DATA), (q.size() > 0) ? 32'(q[0]) : 32'h0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pushKey(input logic [7:0] num);
    step(1'b0, 1'b1, num, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popOne();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset values
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_empty", 32'(oEMPTY), 32'h1);
    check("rst_rd_data", 32'(oRD_DATA), 32'h0);
    idle();

    // Single pulse with code 00
    pushKey(8'h00);
    check("pulse_count", 32'(oCOUNT), 32'h1);
    check("pulse_irq", 32'(oIRQ), 32'h1);
    popOne();

    // Long strobe gives one event
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    idle();
    check("hold_count", 32'(oCOUNT), 32'h1);
    popOne();

    // Strobe held through reset release gives no event
    step(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    check("hold_rst_count", 32'(oCOUNT), 32'h0);
    idle();

    // Fill, overflow, drain, clear overflow
    for (int i = 1; i <= 8; i++) pushKey(8'(i));
    check("fill_full", 32'(oFULL), 32'h1);
    check("fill_count", 32'(oCOUNT), 32'h8);
    pushKey(8'h09);
    check("ovf_set", 32'(oOVF), 32'h1);
    for (int i = 0; i < 8; i++) popOne();
    check("drain_empty", 32'(oEMPTY), 32'h1);
    check("drain_ovf_sticky", 32'(oOVF), 32'h1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", 32'(oOVF), 32'h0);

    // Push and pop together on a full FIFO
    for (int i = 0; i < 8; i++) pushKey(8'h11 + 8'(i));
    step(1'b0, 1'b1, 8'h0A, 1'b1, 1'b0, 1'b0);
    check("full_rw_count", 32'(oCOUNT), 32'h8);
    check("full_rw_ovf", 32'(oOVF), 32'h0);
    idle();
    for (int i = 0; i < 7; i++) popOne();
    check("wrap_last", 32'(oRD_DATA), 32'h0A);
    popOne();

    // Overflow and clear at the same edge: set wins
    for (int i = 0; i < 8; i++) pushKey(8'h40 + 8'(i));
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(oOVF), 32'h1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("flush_empty", 32'(oEMPTY), 32'h1);

    // Push and pop together on an empty FIFO
    step(1'b0, 1'b1, 8'h06, 1'b1, 1'b0, 1'b0);
    check("empty_rw_count", 32'(oCOUNT), 32'h1);
    check("empty_rw_data", 32'(oRD_DATA), 32'h06);
    idle();
    popOne();

    // Flush with 3 entries
    for (int i = 0; i < 3; i++) pushKey(8'hA0 + 8'(i));
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("flush_count", 32'(oCOUNT), 32'h0);
    check("flush_irq", 32'(oIRQ), 32'h0);

    // Reset mid-operation with 5 entries
    for (int i = 0; i < 5; i++) pushKey(8'hB0 + 8'(i));
    step(1'b1, 1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    check("midrst_count", 32'(oCOUNT), 32'h0);
    idle();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 79) == 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_event_fifo.md
Name: keypad_event_fifo

Overview:
- Downstream consumer of the Keypad scanner.
- Captures each key event (rising edge of the scanner's oIRQ) together with the accompanying oKEYNUM code, and queues the events in a small FIFO.
- Presents the events to the processor-side register logic through a first-word-fall-through pop interface, plus a level interrupt and a sticky overflow flag.
- Keystrokes are not lost while software is busy.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, 3, pointer width; equals log2(DEPTH).
- THRESH, 1, interrupt threshold; oIRQ is high when occupancy ≥ THRESH (1..DEPTH).

Ports:
- iCLK  input  1  system clock; all logic on the rising edge.
- iRST  input  1  synchronous, active-high reset.
- iKEY_IRQ  input  1  key-event strobe/level from Keypad oIRQ.
- iKEYNUM  input  8  key code from Keypad oKEYNUM; valid when iKEY_IRQ rises.
- iRD_EN  input  1  pop request; one entry per cycle.
- iFLUSH  input  1  discard all entries (synchronous).
- iOVF_CLR  input  1  clear the sticky overflow flag.
- oRD_DATA  output  8  head entry; valid whenever oEMPTY=0.
- oEMPTY  output  1  FIFO empty.
- oFULL  output  1  FIFO full.
- oCOUNT  output  AW+1  occupancy, 0..DEPTH.
- oOVF  output  1  sticky: an event was dropped because the FIFO was full.
- oIRQ  output  1  level interrupt; high when oCOUNT ≥ THRESH.

Behaviour:
- Reset (iRST=1 at a clock edge):
  - wr_ptr, rd_ptr and count = 0.
  - oEMPTY=1, oFULL=0, oCOUNT=0, oOVF=0, oIRQ=0.
  - oRD_DATA=8'h00 while empty.
  - Edge-detect register prev_irq=1, so a strobe held high through reset does not create an event.
  - Storage contents are don't-care.
  - Reset applied mid-operation discards everything and takes priority over all other inputs.
- Event detect:
  - evt = iKEY_IRQ & ~prev_irq, evaluated at each edge; prev_irq <= iKEY_IRQ.
  - One event per rising edge, however long iKEY_IRQ stays high.
  - iKEYNUM is sampled at the same edge where evt=1.
- Push: evt at edge N writes iKEYNUM into mem[wr_ptr] and increments wr_ptr (wraps modulo DEPTH). New flags and count are visible after edge N.
- Pop: iRD_EN=1 with oEMPTY=0 at edge N increments rd_ptr (wraps); oRD_DATA shows the next entry after edge N.
  - oRD_DATA = mem[rd_ptr] combinationally from the registered pointer (FWFT, zero read latency).
  - A pop while empty is ignored: no pointer change, no error.
- Simultaneous push and pop:
  - Not empty, not full: both happen; count unchanged.
  - Full: pop frees a slot, push is accepted, count stays DEPTH, no overflow.
  - Empty: push only; pop ignored; count becomes 1.
- Overflow: push while full with no pop → data dropped, pointers unchanged, oOVF set to 1 after that edge.
  - oOVF stays set until iOVF_CLR=1 or reset.
  - Overflow and iOVF_CLR at the same edge → oOVF = 1 (set wins).
- Flush: iFLUSH=1 → pointers and count = 0 after the edge. Push and pop at that edge are discarded. oOVF unaffected. Reset outranks flush.
- Flags:
  - oFULL = (count == DEPTH); oEMPTY = (count == 0).
  - count is a registered AW+1-bit counter, separate from the pointers.
- oIRQ is registered from the next-state count; it tracks oCOUNT in the same cycle and has no extra delay.
- No combinational path from any input to any output except iRST-independent oRD_DATA from mem/rd_ptr.

Test Plan:
- Reset, iKEY_IRQ=0, then pulse iKEY_IRQ 1 cycle with iKEYNUM=8'h00 → next cycle oEMPTY=0, oCOUNT=1, oRD_DATA=8'h00, oIRQ=1.
- Hold iKEY_IRQ high 5 cycles with iKEYNUM=8'h08 → exactly one entry (oCOUNT=1). Hold iKEY_IRQ high across reset release → oCOUNT stays 0.
- Push codes 8'h01..8'h08 (DEPTH=8) → oFULL=1, oCOUNT=8. Push 8'h09 → dropped, oOVF=1. Pop 8 times → data 01..08 in order, oEMPTY=1, oIRQ=0, oOVF still 1. Pulse iOVF_CLR → oOVF=0.
- Full FIFO with push 8'h0A and iRD_EN=1 at the same edge → oCOUNT stays 8, oOVF=0, and after 7 more pops the last entry is 8'h0A (wrap-around verified).
- Empty FIFO with push 8'h06 and iRD_EN=1 at the same edge → oCOUNT=1, oRD_DATA=8'h06.
- Load 3 entries, assert iFLUSH → oCOUNT=0, oEMPTY=1, oIRQ=0. Assert iRST mid-operation with 5 entries → all outputs at reset values next cycle.
